// File: rtl/start_sync_memless.sv
// start_sync_memless: entry block of a memoryless dataflow kernel.
// Registers one launch argument from the host, injects it once into the
// circuit entry channel, then waits for the completion token from the end
// block before accepting the next launch. At most one invocation is in
// flight. Exposes an idle flag and a wrapping count of issued launches.
// Every output is decoded from registered state, so no input reaches an
// output combinationally.
module start_sync_memless #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  ins,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    output logic [DATA_WIDTH-1:0]  outs,
    output logic                   outs_valid,
    input  logic                   outs_ready,
    input  logic                   done_valid,
    output logic                   done_ready,
    output logic                   idle,
    output logic [COUNT_WIDTH-1:0] launches
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]             state;
    logic [1:0]             next_state;
    logic [DATA_WIDTH-1:0]  data_reg;
    logic [COUNT_WIDTH-1:0] launch_count;
    logic                   capture;
    logic                   issue_fire;

    // Handshake events, qualified by state so stray valids are ignored.
    assign capture    = (state == S_IDLE)  && ins_valid;
    assign issue_fire = (state == S_ISSUE) && outs_ready;

    // Next-state decode; an unreachable encoding recovers to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (ins_valid)  next_state = S_ISSUE;
            S_ISSUE: if (outs_ready) next_state = S_RUN;
            S_RUN:   if (done_valid) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register; reset discards any in-flight token immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Launch argument is captured only on the accepting IDLE edge and held
    // unchanged through ISSUE, regardless of what the host drives meanwhile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg <= '0;
        end else if (capture) begin
            data_reg <= ins;
        end
    end

    // Counts tokens actually delivered to the circuit; wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            launch_count <= '0;
        end else if (issue_fire) begin
            launch_count <= launch_count + COUNT_WIDTH'(1);
        end
    end

    assign ins_ready  = (state == S_IDLE);
    assign outs_valid = (state == S_ISSUE);
    assign done_ready = (state == S_RUN);
    assign idle       = (state == S_IDLE);
    assign outs       = data_reg;
    assign launches   = launch_count;

endmodule

// File: tb/tb_start_sync_memless.sv
// Directed bench for start_sync_memless with a scoreboard on the entry
// channel: each accepted launch pushes its argument, each entry transfer
// pops and compares. Built with COUNT_WIDTH=2 so the wrap is reachable.
module tb_start_sync_memless;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic [DW-1:0] outs;
    logic          outs_valid;
    logic          outs_ready;
    logic          done_valid;
    logic          done_ready;
    logic          idle;
    logic [CW-1:0] launches;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] sb_q[$];

    start_sync_memless #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .idle       (idle),
        .launches   (launches)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: scoreboard check before the edge, then settle after it.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        if (outs_valid && outs_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL sb_underflow observed=0x%0h expected=none", outs);
            end else begin
                e = sb_q.pop_front();
                chk("sb_outs", 64'(outs), 64'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idle"},       64'(idle),       64'd1);
        chk({tag, "_ins_ready"},  64'(ins_ready),  64'd1);
        chk({tag, "_outs_valid"}, 64'(outs_valid), 64'd0);
        chk({tag, "_done_ready"}, 64'(done_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[5];
        exp_seq = '{1, 2, 3, 0, 1};
        rst = 1'b1; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0; done_valid = 1'b0;

        // Asynchronous reset, mid-cycle, no edge in between
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk_idle("rst_async");
        chk("rst_launches", 64'(launches), 64'd0);
        chk("rst_outs",     64'(outs),     64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk_idle("rst_release");

        // Basic launch
        ins = 32'hDEADBEEF; ins_valid = 1'b1; outs_ready = 1'b1;
        sb_q.push_back(32'hDEADBEEF);
        tick();
        ins_valid = 1'b0;
        chk("basic_outs_valid", 64'(outs_valid), 64'd1);
        chk("basic_outs",       64'(outs),       64'hDEADBEEF);
        chk("basic_ins_ready",  64'(ins_ready),  64'd0);
        chk("basic_cnt_issue",  64'(launches),   64'd0);
        tick();
        chk("basic_done_ready", 64'(done_ready), 64'd1);
        chk("basic_outs_vld0",  64'(outs_valid), 64'd0);
        chk("basic_launches",   64'(launches),   64'd1);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk_idle("basic_done");

        // Backpressure in ISSUE
        ins = 32'hDEADBEEF; ins_valid = 1'b1; outs_ready = 1'b0;
        sb_q.push_back(32'hDEADBEEF);
        tick();
        ins_valid = 1'b0;
        ins = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            chk("bp_outs",       64'(outs),       64'hDEADBEEF);
            chk("bp_outs_valid", 64'(outs_valid), 64'd1);
            chk("bp_ins_ready",  64'(ins_ready),  64'd0);
            chk("bp_launches",   64'(launches),   64'd1);
            tick();
        end
        outs_ready = 1'b1;
        tick();
        chk("bp_launches_after", 64'(launches),   64'd2);
        chk("bp_done_ready",     64'(done_ready), 64'd1);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk_idle("bp_done");

        // Spurious done while IDLE
        done_valid = 1'b1;
        tick();
        tick();
        done_valid = 1'b0;
        chk_idle("spur_done");
        chk("spur_done_cnt", 64'(launches), 64'd2);
        ins = 32'hA5A50001; ins_valid = 1'b1;
        sb_q.push_back(32'hA5A50001);
        tick();
        ins_valid = 1'b0;
        tick();
        chk("spur_run_done_ready", 64'(done_ready), 64'd1);
        chk("spur_run_cnt",        64'(launches),   64'd3);
        // Spurious launch while RUN, held until the block is idle again
        ins = 32'hBAD0BAD0; ins_valid = 1'b1;
        tick();
        tick();
        chk("spur_ins_ready",  64'(ins_ready),  64'd0);
        chk("spur_done_rdy2",  64'(done_ready), 64'd1);
        chk("spur_outs_valid", 64'(outs_valid), 64'd0);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk_idle("spur_back_idle");
        ins = 32'hCAFE0001;
        sb_q.push_back(32'hCAFE0001);
        tick();
        ins_valid = 1'b0;
        chk("spur_capture", 64'(outs), 64'hCAFE0001);
        tick();
        chk("spur_wrap_cnt", 64'(launches), 64'd0);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk_idle("spur_end");

        // Back-to-back invocations with every valid/ready held high
        ins_valid = 1'b1; outs_ready = 1'b1; done_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("b2b_idle", 64'(idle), 64'd1);
            ins = 32'h0BB0_0000 + 32'(i);
            sb_q.push_back(32'h0BB0_0000 + 32'(i));
            tick();
            chk("b2b_issue", 64'(outs_valid), 64'd1);
            tick();
            chk("b2b_run", 64'(done_ready), 64'd1);
            chk("b2b_launches", 64'(launches), 64'(exp_seq[i]));
            tick();
        end
        ins_valid = 1'b0; done_valid = 1'b0;
        chk_idle("b2b_end");

        // Reset while RUN
        ins = 32'h0F0F0F0F; ins_valid = 1'b1;
        sb_q.push_back(32'h0F0F0F0F);
        tick();
        ins_valid = 1'b0;
        tick();
        chk("rr_done_ready_pre", 64'(done_ready), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("rr_async");
        chk("rr_launches", 64'(launches), 64'd0);
        chk("rr_outs",     64'(outs),     64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk_idle("rr_release");
        ins = 32'h13579BDF; ins_valid = 1'b1;
        sb_q.push_back(32'h13579BDF);
        tick();
        ins_valid = 1'b0;
        chk("rr_outs_new", 64'(outs), 64'h13579BDF);
        tick();
        chk("rr_launches_new", 64'(launches), 64'd1);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk_idle("rr_end");

        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
